filter_select_ctrl: RTL

Sequences filter changes for the video filter datapath. It synchronizes and debounces the five filter switches and validates the selection as zero or one-hot. It commits the new filter to the pipeline only at a frame boundary, using a req/ack handshake. It drives the active-low RGB status LED with PWM dimming, and blinks the LED while a change is pending.

---
 rtl/filter_select_ctrl_pkg.sv | 39 +++
 rtl/filter_select_ctrl_if.sv | 25 ++
 rtl/filter_select_ctrl_switch_debounce.sv | 41 ++++
 rtl/filter_select_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/filter_select_ctrl_pkg.sv
// Shared filter codes, LED colours, controller states and selection helpers
// for the filter select controller.
package filter_pkg;

  localparam int SW_W = 5;

  localparam logic [SW_W-1:0] GRAYSCALE = 5'b00001;
  localparam logic [SW_W-1:0] VCONV     = 5'b00010;
  localparam logic [SW_W-1:0] HCONV     = 5'b00100;
  localparam logic [SW_W-1:0] F3        = 5'b01000;
  localparam logic [SW_W-1:0] F4        = 5'b10000;

  // Active-low RGB drive: bit2=R, bit1=G, bit0=B
  localparam logic [2:0] RED     = 3'b011;
  localparam logic [2:0] YELLOW  = 3'b001;
  localparam logic [2:0] CYAN    = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b010;
  localparam logic [2:0] BLUE    = 3'b110;
  localparam logic [2:0] GREEN   = 3'b101;
  localparam logic [2:0] OFF     = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, REQ, ERROR} state_e;

  function automatic logic is_valid_sel(input logic [SW_W-1:0] s);
    return (s & (s - SW_W'(1))) == '0;
  endfunction

  function automatic logic [2:0] sel_color(input logic [SW_W-1:0] s);
    case (s)
      GRAYSCALE: return YELLOW;
      VCONV:     return CYAN;
      HCONV:     return MAGENTA;
      F3:        return BLUE;
      F4:        return GREEN;
      default:   return OFF;
    endcase
  endfunction

endpackage

// File: rtl/filter_select_ctrl_if.sv
// Switch, frame handshake and LED status signals of the filter select controller.
interface filter_select_ctrl_if #(parameter int PWM_BITS = 8);
  import filter_pkg::*;

  logic [SW_W-1:0]     SW;
  logic                frame_start;
  logic                filter_ack;
  logic [PWM_BITS-1:0] brightness;
  logic [SW_W-1:0]     filter_sel;
  logic [SW_W-1:0]     req_sel;
  logic                filter_req;
  logic                pending;
  logic                sel_error;
  logic [2:0]          color;

  modport slave (
    input  SW, frame_start, filter_ack, brightness,
    output filter_sel, req_sel, filter_req, pending, sel_error, color
  );

  modport master (
    output SW, frame_start, filter_ack, brightness,
    input  filter_sel, req_sel, filter_req, pending, sel_error, color
  );
endinterface

// File: rtl/filter_select_ctrl_switch_debounce.sv
// Two-flop synchronizer followed by a hold-time debounce on the whole switch word.
module switch_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q, cand_q, stable_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Saturate so a long-held value never wraps back into a fresh count
  assign cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (cnt_d == LAST) stable_q <= cand_q;
      end
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/filter_select_ctrl.sv
// Filter change sequencer: debounced selection, frame-aligned req/ack commit,
// and a PWM-dimmed status LED that blinks while a change is pending.
module filter_select_ctrl
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  filter_select_ctrl_if.slave bus
);
  localparam int            BW         = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SW_W-1:0]     stable_sw;
  logic [SW_W-1:0]     target_q, target_d;
  logic [SW_W-1:0]     req_sel_q, req_sel_d;
  logic [SW_W-1:0]     filter_sel_q, filter_sel_d;
  logic [BW-1:0]       blink_cnt_q;
  logic                blink_off_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [2:0]          color_q, color_d, base_color;
  logic                sw_valid, pending, enter_wait;

  switch_debounce #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.SW),
    .stable  (stable_sw)
  );

  assign sw_valid   = is_valid_sel(stable_sw);
  assign pending    = (state_q == WAIT_FRAME) || (state_q == REQ);
  assign enter_wait = (state_d == WAIT_FRAME) && (state_q != WAIT_FRAME);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    req_sel_d    = req_sel_q;
    filter_sel_d = filter_sel_q;
    case (state_q)
      IDLE: begin
        if (stable_sw != filter_sel_q) begin
          if (sw_valid) begin
            state_d  = WAIT_FRAME;
            target_d = stable_sw;
          end else begin
            state_d = ERROR;
          end
        end
      end
      // frame_start has priority: a switch change seen on the same cycle is
      // handled after the commit, from IDLE
      WAIT_FRAME: begin
        if (bus.frame_start) begin
          state_d   = REQ;
          req_sel_d = target_q;
        end else if (stable_sw == filter_sel_q) begin
          state_d = IDLE;
        end else if (!sw_valid) begin
          state_d = ERROR;
        end else begin
          target_d = stable_sw;
        end
      end
      REQ: begin
        if (bus.filter_ack) begin
          filter_sel_d = req_sel_q;
          state_d      = IDLE;
        end
      end
      ERROR: begin
        if (sw_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      req_sel_q    <= '0;
      filter_sel_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      req_sel_q    <= req_sel_d;
      filter_sel_q <= filter_sel_d;
    end
  end

  // Blink restarts in the lit phase every time a wait begins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (enter_wait) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (pending) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign base_color = (state_q == ERROR) ? RED
                    : sel_color(pending ? target_q : filter_sel_q);

  always_comb begin
    color_d = OFF;
    if ((pwm_cnt_q < bus.brightness) && !(pending && blink_off_q)) color_d = base_color;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      color_q   <= OFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      color_q   <= color_d;
    end
  end

  assign bus.filter_sel = filter_sel_q;
  assign bus.req_sel    = req_sel_q;
  assign bus.filter_req = (state_q == REQ);
  assign bus.pending    = pending;
  assign bus.sel_error  = (state_q == ERROR);
  assign bus.color      = color_q;
endmodule
